// File: rtl/instr_queue.sv
// instr_queue: decoupling FIFO between the fetcher and the decoder.
// Holds {instruction, PC, predicted-taken} entries in a circular buffer and
// presents the oldest one to the decoder over a valid/ready handshake.
// A misbranch flush empties the queue; a push into a full queue without a
// simultaneous pop is dropped and recorded in a sticky overflow flag.
// Optional feature: define IQ_BYPASS_EN to let a fetch into an empty queue
// reach the decoder outputs in the same cycle.
module instr_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_fetch_valid,
    input  logic [DATA_WIDTH-1:0] in_fetch_instr,
    input  logic [DATA_WIDTH-1:0] in_fetch_pc,
    input  logic                  in_fetch_jump,
    output logic                  out_iq_idle,
    output logic                  out_dec_valid,
    output logic [DATA_WIDTH-1:0] out_dec_instr,
    output logic [DATA_WIDTH-1:0] out_dec_pc,
    output logic                  out_dec_jump,
    input  logic                  in_dec_ready,
    input  logic                  in_misbranch,
    output logic [PTR_W:0]        out_count,
    output logic                  out_overflow
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   IDLE_LIMIT = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [DATA_WIDTH-1:0] instrMem_q [DEPTH];
    logic [DATA_WIDTH-1:0] pcMem_q    [DEPTH];
    logic [DEPTH-1:0]      jumpMem_q;

    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic queueValid;
    logic queueFull;
    logic pushReq;
    logic popReq;
    logic flushReq;
    logic bypassActive;
    logic bypassConsume;
    logic doPush;
    logic doPop;
    logic pushDropped;

    assign queueValid = (count_q != '0);
    assign queueFull  = (count_q == FULL_COUNT);

`ifdef IQ_BYPASS_EN
    // An empty queue forwards the incoming fetch straight to the decoder.
    assign bypassActive = (count_q == '0) & in_fetch_valid & rdy & ~in_misbranch;
`else
    assign bypassActive = 1'b0;
`endif

    // An entry taken by the decoder in its bypass cycle never touches storage.
    assign bypassConsume = bypassActive & in_dec_ready;

    assign flushReq    = rdy & in_misbranch;
    assign pushReq     = rdy & in_fetch_valid & ~in_misbranch;
    assign popReq      = rdy & out_dec_valid & in_dec_ready & ~in_misbranch;
    assign doPush      = pushReq & (~queueFull | popReq) & ~bypassConsume;
    assign doPop       = popReq & ~bypassConsume;
    assign pushDropped = pushReq & queueFull & ~popReq;

    // Decoder-facing view of the head entry, overridden by the bypass path when enabled.
    always_comb begin
        out_dec_valid = queueValid;
        out_dec_instr = instrMem_q[headPtr_q];
        out_dec_pc    = pcMem_q[headPtr_q];
        out_dec_jump  = jumpMem_q[headPtr_q];
`ifdef IQ_BYPASS_EN
        if (bypassActive) begin
            out_dec_valid = 1'b1;
            out_dec_instr = in_fetch_instr;
            out_dec_pc    = in_fetch_pc;
            out_dec_jump  = in_fetch_jump;
        end
`endif
    end

    // One slot of slack covers the fetcher's registered push that follows its idle sample.
    assign out_iq_idle  = (count_q < IDLE_LIMIT);
    assign out_count    = count_q;
    assign out_overflow = overflow_q;

    // Next pointers and occupancy; a flush overrides any same-cycle push or pop.
    always_comb begin
        headPtr_d  = headPtr_q;
        tailPtr_d  = tailPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q | pushDropped;
        if (flushReq) begin
            headPtr_d = '0;
            tailPtr_d = '0;
            count_d   = '0;
        end else begin
            if (doPush) begin
                tailPtr_d = tailPtr_q + PTR_ONE;
            end
            if (doPop) begin
                headPtr_d = headPtr_q + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            headPtr_q  <= '0;
            tailPtr_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            headPtr_q  <= headPtr_d;
            tailPtr_q  <= tailPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage is not reset; valid gating hides stale contents.
    always_ff @(posedge clk) begin
        if (doPush) begin
            instrMem_q[tailPtr_q] <= in_fetch_instr;
            pcMem_q[tailPtr_q]    <= in_fetch_pc;
            jumpMem_q[tailPtr_q]  <= in_fetch_jump;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: self-checking bench for instr_queue (DEPTH 16, 32-bit data).
// Combines a constant-expectation vector table, directed corner sequences and
// a randomized run compared against a queue-based reference model.
module tb_instr_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
        logic          jump;
    } entry_t;

    typedef struct {
        logic          r;
        logic          fv;
        logic [DW-1:0] pc;
        logic          dr;
        logic          mb;
        int            expCount;
        logic          expValid;
        logic [DW-1:0] expPc;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic          in_fetch_valid;
    logic [DW-1:0] in_fetch_instr;
    logic [DW-1:0] in_fetch_pc;
    logic          in_fetch_jump;
    logic          out_iq_idle;
    logic          out_dec_valid;
    logic [DW-1:0] out_dec_instr;
    logic [DW-1:0] out_dec_pc;
    logic          out_dec_jump;
    logic          in_dec_ready;
    logic          in_misbranch;
    logic [PW:0]   out_count;
    logic          out_overflow;

    entry_t modelQ[$];
    logic   modelOvf;
    int     assertCount;
    int     failCount;
    vec_t   vecs[15];

    instr_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .in_fetch_valid(in_fetch_valid),
        .in_fetch_instr(in_fetch_instr),
        .in_fetch_pc   (in_fetch_pc),
        .in_fetch_jump (in_fetch_jump),
        .out_iq_idle   (out_iq_idle),
        .out_dec_valid (out_dec_valid),
        .out_dec_instr (out_dec_instr),
        .out_dec_pc    (out_dec_pc),
        .out_dec_jump  (out_dec_jump),
        .in_dec_ready  (in_dec_ready),
        .in_misbranch  (in_misbranch),
        .out_count     (out_count),
        .out_overflow  (out_overflow)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, got, exp);
        end
    endtask

    // Compare every DUT output against the reference queue (fetch input idle at this point).
    task automatic checkOutput(input string tag);
        logic expValid;
        expValid = (modelQ.size() != 0);
        checkEq({tag, " count"}, DW'(out_count), DW'(modelQ.size()));
        checkEq({tag, " valid"}, DW'(out_dec_valid), DW'(expValid));
        checkEq({tag, " idle"}, DW'(out_iq_idle), DW'(modelQ.size() < DEPTH - 1));
        checkEq({tag, " overflow"}, DW'(out_overflow), DW'(modelOvf));
        if (expValid) begin
            checkEq({tag, " pc"}, out_dec_pc, modelQ[0].pc);
            checkEq({tag, " instr"}, out_dec_instr, modelQ[0].instr);
            checkEq({tag, " jump"}, DW'(out_dec_jump), DW'(modelQ[0].jump));
        end
    endtask

    // Reference behaviour for one clock edge, expressed on a plain queue.
    task automatic modelStep(input logic r, input logic fv, input entry_t e, input logic dr, input logic mb);
        int   sz;
        logic mValid;
        logic pop;
        logic accept;
        sz = modelQ.size();
        if (!r) return;
        if (mb) begin
            modelQ.delete();
            return;
        end
        mValid = (sz != 0);
`ifdef IQ_BYPASS_EN
        if (sz == 0 && fv) mValid = 1'b1;
`endif
        pop = mValid && dr;
        if (pop && sz == 0) return;
        accept = fv && (sz < DEPTH || pop);
        if (fv && !accept) modelOvf = 1'b1;
        if (pop) void'(modelQ.pop_front());
        if (accept) modelQ.push_back(e);
    endtask

    // Drive one cycle of inputs, advance one edge, then leave the fetch/flush pulses low.
    task automatic applyStimulus(input logic r, input logic fv, input logic [DW-1:0] instr,
                                 input logic [DW-1:0] pc, input logic jump,
                                 input logic dr, input logic mb);
        entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.jump  = jump;
        rdy            = r;
        in_fetch_valid = fv;
        in_fetch_instr = instr;
        in_fetch_pc    = pc;
        in_fetch_jump  = jump;
        in_dec_ready   = dr;
        in_misbranch   = mb;
        @(posedge clk);
        modelStep(r, fv, e, dr, mb);
        #1;
        in_fetch_valid = 1'b0;
        in_misbranch   = 1'b0;
        #1;
    endtask

    task automatic pushPc(input logic [DW-1:0] pc, input logic dr);
        applyStimulus(1'b1, 1'b1, ~pc, pc, pc[2], dr, 1'b0);
    endtask

    task automatic applyReset();
        rst            = 1'b0;
        rdy            = 1'b0;
        in_fetch_valid = 1'b0;
        in_fetch_instr = '0;
        in_fetch_pc    = '0;
        in_fetch_jump  = 1'b0;
        in_dec_ready   = 1'b0;
        in_misbranch   = 1'b0;
        modelQ.delete();
        modelOvf = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkEq("reset valid", DW'(out_dec_valid), DW'(1'b0));
        checkEq("reset idle", DW'(out_iq_idle), DW'(1'b1));
        checkEq("reset count", DW'(out_count), DW'(0));
        checkEq("reset overflow", DW'(out_overflow), DW'(1'b0));
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] pcNext;
        logic [DW-1:0] rpc;
        assertCount = 0;
        failCount   = 0;

        // Vector table: inputs for one cycle, expected state after its edge.
        vecs[0]  = '{1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 1, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'h4,   1'b0, 1'b0, 2, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 32'h8,   1'b0, 1'b0, 3, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 2, 1'b1, 32'h4};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1, 1'b1, 32'h8};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'hC,   1'b1, 1'b0, 0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 32'h10,  1'b0, 1'b0, 1, 1'b1, 32'h10};
        vecs[8]  = '{1'b0, 1'b1, 32'h14,  1'b1, 1'b0, 1, 1'b1, 32'h10};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 32'h20,  1'b0, 1'b0, 1, 1'b1, 32'h20};
        vecs[11] = '{1'b1, 1'b1, 32'h24,  1'b0, 1'b1, 0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1, 1'b1, 32'h100};
        vecs[13] = '{1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 1, 1'b1, 32'h104};
        vecs[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 0, 1'b0, 32'h0};

        applyReset();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].r, vecs[i].fv, ~vecs[i].pc, vecs[i].pc, vecs[i].pc[2],
                          vecs[i].dr, vecs[i].mb);
            checkEq($sformatf("vec%0d count", i), DW'(out_count), DW'(vecs[i].expCount));
            checkEq($sformatf("vec%0d valid", i), DW'(out_dec_valid), DW'(vecs[i].expValid));
            checkEq($sformatf("vec%0d idle", i), DW'(out_iq_idle), DW'(vecs[i].expCount < DEPTH - 1));
            if (vecs[i].expValid) begin
                checkEq($sformatf("vec%0d pc", i), out_dec_pc, vecs[i].expPc);
            end
            checkOutput($sformatf("vec%0d model", i));
        end

        // Fill to full, overflow on the 17th push, then push+pop while full.
        applyReset();
        for (int i = 0; i < 15; i++) begin
            pushPc(32'h1000 + 32'(4 * i), 1'b0);
            if (i == 13) checkEq("fill idle at 14", DW'(out_iq_idle), DW'(1'b1));
        end
        checkEq("fill idle at 15", DW'(out_iq_idle), DW'(1'b0));
        checkEq("fill count 15", DW'(out_count), DW'(15));
        pushPc(32'h103C, 1'b0);
        checkEq("full count 16", DW'(out_count), DW'(16));
        checkEq("full no overflow", DW'(out_overflow), DW'(1'b0));
        pushPc(32'h1040, 1'b0);
        checkEq("drop count 16", DW'(out_count), DW'(16));
        checkEq("drop overflow", DW'(out_overflow), DW'(1'b1));
        checkOutput("drop model");
        pushPc(32'h1044, 1'b1);
        checkEq("full pushpop count", DW'(out_count), DW'(16));
        checkEq("full pushpop head", out_dec_pc, 32'h1004);
        pcNext = 32'h1048;
        for (int i = 0; i < 40; i++) begin
            pushPc(pcNext, 1'b1);
            pcNext = pcNext + 32'h4;
            checkEq($sformatf("stream%0d count", i), DW'(out_count), DW'(16));
            checkOutput($sformatf("stream%0d", i));
        end

        // Asynchronous reset between edges clears state immediately.
        #2;
        rst = 1'b0;
        #1;
        checkEq("async rst valid", DW'(out_dec_valid), DW'(1'b0));
        checkEq("async rst count", DW'(out_count), DW'(0));
        checkEq("async rst overflow", DW'(out_overflow), DW'(1'b0));
        checkEq("async rst idle", DW'(out_iq_idle), DW'(1'b1));
        modelQ.delete();
        modelOvf = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Flush with five entries plus a same-cycle push and ready.
        for (int i = 0; i < 5; i++) pushPc(32'h200 + 32'(4 * i), 1'b0);
        checkEq("pre-flush count", DW'(out_count), DW'(5));
        applyStimulus(1'b1, 1'b1, 32'hDEAD, 32'h300, 1'b1, 1'b1, 1'b1);
        checkEq("flush count", DW'(out_count), DW'(0));
        checkEq("flush valid", DW'(out_dec_valid), DW'(1'b0));
        pushPc(32'h100, 1'b0);
        checkEq("post-flush head", out_dec_pc, 32'h100);
        checkEq("post-flush count", DW'(out_count), DW'(1));
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("post-flush drain");

        // rdy low for three cycles inside a push/pop stream freezes everything.
        for (int i = 0; i < 3; i++) pushPc(32'h400 + 32'(4 * i), 1'b0);
        pcNext = 32'h40C;
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i < 3 || i > 5), 1'b1, ~pcNext, pcNext, pcNext[2], 1'b1, 1'b0);
            if (i < 3 || i > 5) pcNext = pcNext + 32'h4;
            checkEq($sformatf("freeze%0d count", i), DW'(out_count), DW'(3));
            checkOutput($sformatf("freeze%0d", i));
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("freeze drained");

`ifdef IQ_BYPASS_EN
        // Empty queue: a fetch reaches the decoder in the same cycle and is consumed.
        rdy            = 1'b1;
        in_fetch_valid = 1'b1;
        in_fetch_instr = 32'hCAFE;
        in_fetch_pc    = 32'h500;
        in_fetch_jump  = 1'b1;
        in_dec_ready   = 1'b1;
        in_misbranch   = 1'b0;
        #1;
        checkEq("bypass valid", DW'(out_dec_valid), DW'(1'b1));
        checkEq("bypass pc", out_dec_pc, 32'h500);
        applyStimulus(1'b1, 1'b1, 32'hCAFE, 32'h500, 1'b1, 1'b1, 1'b0);
        checkEq("bypass count", DW'(out_count), DW'(0));
        checkOutput("bypass model");
`endif

        // Randomized traffic against the reference model.
        rpc = 32'h8000;
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic fv;
            logic dr;
            logic mb;
            r  = ($urandom_range(0, 9) != 0);
            fv = ($urandom_range(0, 9) < 6);
            dr = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 7));
            mb = ($urandom_range(0, 39) == 0);
            applyStimulus(r, fv, $urandom, rpc, 1'($urandom_range(0, 1)), dr, mb);
            if (fv) rpc = rpc + 32'h4;
            checkOutput($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
